morse_sequencer: RTL and testbench
==================================

# morse_sequencer

Controller that sequences the Morse-code lamp for the letter-display lab. On a start request it latches a 3-bit letter code (A–H), looks up its dot/dash pattern and symbol count, and paces the lamp with an internal half-second unit tick: dot = 1 unit on, dash = 3 units on, 1 unit off after every symbol. It sits between the board switches/KEY inputs and the LEDR lamp. It replaces the free-running enable counter plus the ad-hoc dot/dash FSM with one controller that owns the lamp.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥2; benches use 4.
- `DASH_UNITS`, default 3: on-time of a dash, in units.
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `start`  in  1  request to send a letter; sampled only in IDLE.
- `letter`  in  3  letter code, A=0 … H=7; sampled in the same cycle as an accepted start.
- `light`  out  1  lamp drive; high during a symbol's on-time.
- `is_dash`  out  1  high while the current on-time is a dash; 0 otherwise.
- `busy`  out  1  high from the cycle after an accepted start until the done cycle.
- `done`  out  1  one-cycle pulse when a letter completes.

## Operation
- Patterns are sent MSB-first, with 1 = dash:
  - A `.-` (len 2)
  - B `-...` (4)
  - C `-.-.` (4)
  - D `-..` (3)
  - E `.` (1)
  - F `..-.` (4)
  - G `--.` (3)
  - H `....` (4)
- States:
  - IDLE: light=0, busy=0. When start=1, load the 4-bit shift register with the left-aligned pattern and load `remaining` with the length. Clear the prescaler and unit counter, then go to ON.
  - ON: light=1, busy=1, is_dash = shift MSB. On each tick, increment the unit counter. When it reaches the symbol's units (1 for a dot, DASH_UNITS for a dash) at a tick, clear it, decrement `remaining`, and go to GAP.
  - GAP: light=0, busy=1. On the next tick, either:
    - if remaining=0: go to IDLE and assert done for one cycle;
    - else: shift the pattern left and go to ON.
- Prescaler: counts 0…TICK_DIV-1 and wraps. tick=1 when count = TICK_DIV-1. It is forced to 0 when a start is accepted, so every letter is phase-aligned.
- Boundary behaviour:
  - start while busy: ignored. letter changes while busy: ignored.
  - start held high through completion: a new letter is accepted in the done cycle, since the state is IDLE then.
  - Reset mid-letter: next cycle IDLE, all outputs 0, no done pulse, prescaler cleared.
  - Undefined states recover to IDLE.
- Reset values: light=0, is_dash=0, busy=0, done=0, state=IDLE, prescaler=0.

## Timing
- Cycle 0 is the cycle in which start is high in IDLE. light and busy rise in cycle 1; all outputs are registered.
- Each unit is TICK_DIV cycles:
  - dot on-time = TICK_DIV cycles;
  - dash on-time = DASH_UNITS×TICK_DIV cycles;
  - gap = TICK_DIV cycles.
- done is high in cycle 1 + Σ(on + gap) and busy is low in that same cycle.
- Letter latency, in units: Σ symbol units + number of symbols.
- Widths: prescaler uses $clog2(TICK_DIV) bits; unit counter 2 bits; remaining 3 bits.

## Structure
- Package `morse_pkg` holds:
  - the state enum (IDLE, ON, GAP);
  - the letter code constants;
  - the pattern/length constants per letter.
- One natural sub-module, `morse_rom`: combinational letter → {pattern[3:0], len[2:0]}.
- The prescaler stays inline; it is the only counter needing a parameterised width.

## Test plan
All scenarios use TICK_DIV=4 and DASH_UNITS=3.
- Reset: assert reset for 2 cycles with start=1 → light/busy/done/is_dash all 0, no start accepted.
- E (letter=4) started at cycle 0 → light high cycles 1–4, busy 1–8, done high only in cycle 9.
- A (letter=0) → light 1–4 (is_dash=0), light 9–20 (is_dash=1), gaps 5–8 and 21–24, done in cycle 25.
- H (letter=7) → four 4-cycle pulses starting at cycles 1, 9, 17, 25; done in cycle 33.
- Busy protection: start A, then pulse start with letter=7 at cycle 6 → waveform identical to the A case; start held high throughout → next letter's light rises in cycle 26.
- Reset mid-operation: B started, reset at cycle 10 → cycle 11 light=0, busy=0, no done. A fresh E start then produces the normal E waveform.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and letter tables for the Morse lamp sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  // Patterns are left-aligned, MSB sent first, 1 = dash.
  localparam logic [3:0] PAT_A = 4'b0100;
  localparam logic [3:0] PAT_B = 4'b1000;
  localparam logic [3:0] PAT_C = 4'b1010;
  localparam logic [3:0] PAT_D = 4'b1000;
  localparam logic [3:0] PAT_E = 4'b0000;
  localparam logic [3:0] PAT_F = 4'b0010;
  localparam logic [3:0] PAT_G = 4'b1100;
  localparam logic [3:0] PAT_H = 4'b0000;

  localparam logic [2:0] LEN_A = 3'd2;
  localparam logic [2:0] LEN_B = 3'd4;
  localparam logic [2:0] LEN_C = 3'd4;
  localparam logic [2:0] LEN_D = 3'd3;
  localparam logic [2:0] LEN_E = 3'd1;
  localparam logic [2:0] LEN_F = 3'd4;
  localparam logic [2:0] LEN_G = 3'd3;
  localparam logic [2:0] LEN_H = 3'd4;

endpackage

// File: rtl/morse_rom.sv
// Combinational letter -> {pattern, length} lookup.
module morse_rom
  import morse_pkg::*;
(
  input  logic [2:0] letter_i,
  output logic [3:0] pattern_o,
  output logic [2:0] len_o
);

  always_comb begin
    pattern_o = PAT_E;
    len_o     = LEN_E;
    case (letter_i)
      LTR_A: begin pattern_o = PAT_A; len_o = LEN_A; end
      LTR_B: begin pattern_o = PAT_B; len_o = LEN_B; end
      LTR_C: begin pattern_o = PAT_C; len_o = LEN_C; end
      LTR_D: begin pattern_o = PAT_D; len_o = LEN_D; end
      LTR_E: begin pattern_o = PAT_E; len_o = LEN_E; end
      LTR_F: begin pattern_o = PAT_F; len_o = LEN_F; end
      LTR_G: begin pattern_o = PAT_G; len_o = LEN_G; end
      LTR_H: begin pattern_o = PAT_H; len_o = LEN_H; end
      default: begin pattern_o = PAT_E; len_o = LEN_E; end
    endcase
  end

endmodule

// File: rtl/morse_sequencer.sv
// Morse lamp controller: latches a letter, paces dots/dashes/gaps off a unit tick.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int DASH_UNITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] letter,
  output logic       light,
  output logic       is_dash,
  output logic       busy,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    shift_q, shift_d;
  logic [2:0]    rem_q, rem_d;
  logic [1:0]    unit_q, unit_d;
  logic          done_q, done_d;

  logic          tick;
  logic [1:0]    unit_inc;
  logic [1:0]    sym_units;
  logic [3:0]    rom_pattern;
  logic [2:0]    rom_len;

  morse_rom u_rom (
    .letter_i  (letter),
    .pattern_o (rom_pattern),
    .len_o     (rom_len)
  );

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign unit_inc  = unit_q + 2'd1;
  assign sym_units = shift_q[3] ? 2'(DASH_UNITS) : 2'd1;

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    shift_d = shift_q;
    rem_d   = rem_q;
    unit_d  = unit_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = rom_pattern;
          rem_d   = rom_len;
          unit_d  = '0;
          presc_d = '0;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (tick) begin
          if (unit_inc == sym_units) begin
            unit_d  = '0;
            rem_d   = rem_q - 3'd1;
            state_d = ST_GAP;
          end else begin
            unit_d = unit_inc;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (rem_q == 3'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            shift_d = {shift_q[2:0], 1'b0};
            state_d = ST_ON;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      shift_q <= '0;
      rem_q   <= '0;
      unit_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      unit_q  <= unit_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode straight from flops, so they are registered without extra latency.
  assign light   = (state_q == ST_ON);
  assign is_dash = (state_q == ST_ON) && shift_q[3];
  assign busy    = (state_q == ST_ON) || (state_q == ST_GAP);
  assign done    = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench: per-cycle waveform model built from the letter strings.
module tb_morse_sequencer;

  localparam int TD = 4;
  localparam int DU = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] letter = 3'd0;
  logic       light, is_dash, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  string pats [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  morse_sequencer #(.TICK_DIV(TD), .DASH_UNITS(DU)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .letter  (letter),
    .light   (light),
    .is_dash (is_dash),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic int sym_units(byte ch);
    return (ch == "-") ? DU : 1;
  endfunction

  function automatic int done_cycle(int l);
    int t = 1;
    for (int i = 0; i < pats[l].len(); i++) t += (sym_units(pats[l][i]) + 1) * TD;
    return t;
  endfunction

  // Expected {light, is_dash, busy, done} in cycle c after start in cycle 0.
  function automatic logic [3:0] expect_at(int l, int c);
    int  t;
    int  on;
    byte ch;
    if (c < 1) return 4'b0000;
    t = c - 1;
    for (int i = 0; i < pats[l].len(); i++) begin
      ch = pats[l][i];
      on = sym_units(ch) * TD;
      if (t < on) return {1'b1, (ch == "-"), 1'b1, 1'b0};
      t -= on;
      if (t < TD) return 4'b0010;
      t -= TD;
    end
    return (t == 0) ? 4'b0001 : 4'b0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [3:0] exp);
    logic [3:0] obs;
    obs = {light, is_dash, busy, done};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {light,dash,busy,done}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Random idle spacing (varies prescaler phase), then cycle 0 with start high.
  task automatic begin_letter(int l);
    int gap = $urandom_range(0, 5);
    for (int i = 0; i < gap; i++) begin
      step();
      start = 1'b0;
      chk("idle", 4'b0000);
    end
    step();
    start  = 1'b1;
    letter = 3'(l);
    chk("c0", 4'b0000);
  endtask

  // Walks cycles 1..done of letter l; current cycle must be its cycle 0.
  task automatic run_letter(int l, bit hold, int nxt, bit noise, int inj_at, int abort_at);
    int d = done_cycle(l);
    for (int c = 1; c <= d; c++) begin
      step();
      if (abort_at != 0 && c == abort_at + 1) begin
        reset = 1'b0;
        start = 1'b0;
        chk($sformatf("abort L%0d c%0d", l, c), 4'b0000);
        for (int k = 0; k < d; k++) begin
          step();
          chk("abort_idle", 4'b0000);
        end
        return;
      end
      if (abort_at != 0 && c == abort_at) reset = 1'b1;
      if (hold) begin
        start = 1'b1;
        if (c == d) letter = 3'(nxt);
      end else if (c < d) begin
        start = (c == inj_at) || (noise && ($urandom_range(0, 3) == 0));
        if (c == inj_at) letter = 3'd7;
        else if (noise) letter = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      chk($sformatf("L%0d c%0d", l, c), expect_at(l, c));
    end
  endtask

  initial begin
    int l, n;
    reset = 1'b1;
    start = 1'b1;
    letter = 3'd4;
    step(); chk("rst0", 4'b0000);
    step(); chk("rst1", 4'b0000);
    step(); reset = 1'b0; start = 1'b0; chk("rst_rel", 4'b0000);
    step(); chk("post_rst", 4'b0000);

    begin_letter(4); run_letter(4, 1'b0, 0, 1'b0, 0, 0);
    begin_letter(0); run_letter(0, 1'b0, 0, 1'b0, 0, 0);
    begin_letter(7); run_letter(7, 1'b0, 0, 1'b0, 0, 0);

    // start pulse with a different letter while busy must not disturb A
    begin_letter(0); run_letter(0, 1'b0, 0, 1'b0, 6, 0);

    // start held: next A accepted in the done cycle, light rises one cycle later
    begin_letter(0); run_letter(0, 1'b1, 0, 1'b0, 0, 0);
    run_letter(0, 1'b0, 0, 1'b0, 0, 0);

    // reset mid-letter, then a clean E
    begin_letter(1); run_letter(1, 1'b0, 0, 1'b0, 0, 10);
    begin_letter(4); run_letter(4, 1'b0, 0, 1'b0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      l = $urandom_range(0, 7);
      begin_letter(l);
      run_letter(l, 1'b0, 0, 1'b1, 0, 0);
    end

    // random back-to-back chain with start held
    l = $urandom_range(0, 7);
    begin_letter(l);
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 7);
      run_letter(l, 1'b1, n, 1'b0, 0, 0);
      l = n;
    end
    run_letter(l, 1'b0, 0, 1'b0, 0, 0);

    // random reset abort point
    l = $urandom_range(0, 7);
    begin_letter(l);
    run_letter(l, 1'b0, 0, 1'b0, 0, $urandom_range(1, done_cycle(l) - 1));
    begin_letter(2); run_letter(2, 1'b0, 0, 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
